// File: rtl/sram_like_rr_arbiter.sv
// Round-robin merge of two sram-like masters onto one slave port, with an
// in-order ID FIFO that steers each data_ok/rdata back to the issuing master.
module sram_like_rr_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_wr,
    input  logic [1:0]       m0_size,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic [31:0]      m0_rdata,
    output logic             m0_addr_ok,
    output logic             m0_data_ok,
    input  logic             m1_req,
    input  logic             m1_wr,
    input  logic [1:0]       m1_size,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic [31:0]      m1_rdata,
    output logic             m1_addr_ok,
    output logic             m1_data_ok,
    output logic             s_req,
    output logic             s_wr,
    output logic [1:0]       s_size,
    output logic [31:0]      s_addr,
    output logic [31:0]      s_wdata,
    input  logic [31:0]      s_rdata,
    input  logic             s_addr_ok,
    input  logic             s_data_ok,
    output logic [CNT_W-1:0] outst_cnt,
    output logic             err_unexp
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

    // Explicit wrap keeps the pointer legal when MAX_OUTST is 1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic                 last_gnt_q;
    logic                 lock_q;
    logic                 lock_id_q;
    logic [MAX_OUTST-1:0] fifo_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 err_q;

    logic sel_s;
    logic sel_vld_s;
    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    // Grant selection: a pending lock pins the grant to the offered request.
    always_comb begin
        sel_s     = 1'b0;
        sel_vld_s = 1'b0;
        if (lock_q) begin
            sel_s     = lock_id_q;
            sel_vld_s = 1'b1;
        end else if (m0_req && m1_req) begin
            sel_s     = ~last_gnt_q;
            sel_vld_s = 1'b1;
        end else if (m0_req) begin
            sel_s     = 1'b0;
            sel_vld_s = 1'b1;
        end else if (m1_req) begin
            sel_s     = 1'b1;
            sel_vld_s = 1'b1;
        end else begin
            sel_s     = 1'b0;
            sel_vld_s = 1'b0;
        end
    end

    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign head_s  = fifo_q[rd_ptr_q];

    assign s_req   = ~reset & sel_vld_s & (sel_s ? m1_req : m0_req) & ~full_s;
    assign s_wr    = sel_s ? m1_wr    : m0_wr;
    assign s_size  = sel_s ? m1_size  : m0_size;
    assign s_addr  = sel_s ? m1_addr  : m0_addr;
    assign s_wdata = sel_s ? m1_wdata : m0_wdata;

    assign push_s = s_req & s_addr_ok;
    assign pop_s  = ~reset & s_data_ok & ~empty_s;

    assign m0_addr_ok = push_s & ~sel_s;
    assign m1_addr_ok = push_s &  sel_s;
    assign m0_data_ok = pop_s  & ~head_s;
    assign m1_data_ok = pop_s  &  head_s;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    assign outst_cnt = reset ? {CNT_W{1'b0}} : count_q;
    assign err_unexp = err_q;

    // Arbitration history, lock, order FIFO and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            fifo_q     <= {MAX_OUTST{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            if (push_s) begin
                lock_q           <= 1'b0;
                fifo_q[wr_ptr_q] <= sel_s;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                last_gnt_q       <= sel_s;
            end else if (s_req) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel_s;
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (s_data_ok && empty_s) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
